udp_result_tx: RTL and testbench
================================

UDP_RESULT_TX -- requirements
Module: udp_result_tx

Interface
REQ-001 The module SHALL have parameter MEM_ADDRESS_BIT_WIDTH, default 8, meaning the SRAM word address width.
REQ-002 The module SHALL have parameter MEM_DATA_BIT_WIDTH, default 512, meaning the SRAM read word width (the accelerator result width).
REQ-003 The module SHALL have parameter UDP_DATA_BIT_WIDTH, default 8, meaning the outgoing UDP byte-stream width.
REQ-004 Port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1, meaning a synchronous, active-high reset.
REQ-006 Port start_i, input, 1, meaning a one-cycle request to send one packet.
REQ-007 Port base_addr_i, input, MEM_ADDRESS_BIT_WIDTH, meaning the first SRAM word address; sampled when start_i is accepted.
REQ-008 Port word_count_i, input, MEM_ADDRESS_BIT_WIDTH+1, meaning the number of words to send (0..256); sampled when start_i is accepted.
REQ-009 Port src_port_i, input, 16; port dest_port_i, input, 16; port dest_addr_i, input, 32; meaning the UDP header fields; all sampled when start_i is accepted.
REQ-010 Port busy_o, output, 1, meaning a packet is in progress.
REQ-011 Port done_o, output, 1, meaning a one-cycle pulse when a packet completes.
REQ-012 Port mem_rd_en_o, output, 1, meaning an SRAM read strobe.
REQ-013 Port mem_addr_o, output, MEM_ADDRESS_BIT_WIDTH, meaning the SRAM read address.
REQ-014 Port mem_data_i, input, MEM_DATA_BIT_WIDTH, meaning the SRAM read data, valid exactly one cycle after mem_rd_en_o.
REQ-015 Port og_data_o, output, UDP_DATA_BIT_WIDTH, meaning the outgoing data byte.
REQ-016 Ports og_valid_o, og_sof_o and og_eof_o, outputs, 1 each, meaning data valid, first byte of packet, and last byte of packet.
REQ-017 Port og_ready_i, input, 1, meaning the UDP core accepts the byte.
REQ-018 Ports og_src_port_o (16), og_dest_port_o (16) and og_dest_addr_o (32), outputs, meaning the sampled header fields, held stable for the whole packet.

Function
REQ-019 The FSM SHALL have the states IDLE, READ, CAPTURE, SEND and DONE, and all outputs SHALL be registered.
REQ-020 IDLE: on start_i with word_count_i nonzero, the FSM SHALL sample the inputs, assert busy_o and go to READ.
REQ-021 IDLE: on start_i with word_count_i equal to zero, the FSM SHALL go to DONE without issuing a read or sending any byte.
REQ-022 READ: the FSM SHALL assert mem_rd_en_o for exactly one cycle with mem_addr_o set to the current address, then go to CAPTURE.
REQ-023 CAPTURE: the FSM SHALL load mem_data_i into a 512-bit shift register, set a byte index to 0, and go to SEND.
REQ-024 SEND: bytes SHALL be sent most-significant byte first (bits [511:504] first), 64 bytes per word.
REQ-025 A byte SHALL transfer only on a cycle where og_valid_o and og_ready_i are both high.
REQ-026 While og_ready_i is low, og_valid_o, og_data_o, og_sof_o and og_eof_o SHALL hold stable, and og_valid_o SHALL never drop before its byte is accepted.
REQ-027 og_sof_o SHALL be high only on byte 0 of word 0.
REQ-028 og_eof_o SHALL be high only on byte 63 of the last word.
REQ-029 When byte 63 of a word is accepted and words remain, the address SHALL increment modulo 2^MEM_ADDRESS_BIT_WIDTH (255 wraps to 0) and the FSM SHALL go to READ.
REQ-030 When byte 63 of the last word is accepted, the FSM SHALL go to DONE.
REQ-031 DONE: the FSM SHALL pulse done_o for one cycle, clear busy_o and return to IDLE.
REQ-032 Latency: with start_i at cycle 0 and og_ready_i held high, mem_rd_en_o SHALL be high at cycle 1 and the first og_valid_o at cycle 3.
REQ-033 Each inter-word gap SHALL be exactly 2 cycles with og_valid_o low.
REQ-034 A packet of N words with og_ready_i held high SHALL complete in 66*N+2 cycles from start_i to done_o.
REQ-035 start_i SHALL be ignored when not in IDLE (including in DONE); parameters sampled for the current packet SHALL be unaffected.
REQ-036 The word counter SHALL be 9 bits so that a count of 256 sends exactly 256 words.

Reset
REQ-037 While reset is high, the FSM SHALL be in IDLE and busy_o, done_o, mem_rd_en_o, og_valid_o, og_sof_o and og_eof_o SHALL be 0.
REQ-038 While reset is high, mem_addr_o, og_data_o, the header outputs, the counters and the shift register SHALL be 0.
REQ-039 Reset mid-packet SHALL abort the packet: no og_eof_o and no done_o are emitted, and the next start_i begins a fresh packet with og_sof_o.

Structure
REQ-040 The state encoding, the BYTES_PER_WORD constant (MEM_DATA_BIT_WIDTH/UDP_DATA_BIT_WIDTH = 64) and the header field widths SHALL live in the shared cnna_pkg package.
REQ-041 The block SHALL be a single module with no sub-modules; the shift register, FSM and counters SHALL be inline.

Verification
REQ-042 The bench SHALL cover: start with base=0x10, count=1, ready always high -> one read at 0x10 and 64 bytes MSB-first, sof on byte 0, eof on byte 63, done_o at cycle 68.
REQ-043 The bench SHALL cover: base=0xFE, count=3 -> reads at 0xFE, 0xFF, 0x00; 192 bytes; exactly one sof and one eof.
REQ-044 The bench SHALL cover: random og_ready_i stalls at 50% -> byte stream identical to the no-stall run and outputs stable during every stall.
REQ-045 The bench SHALL cover: count=0 -> no mem_rd_en_o, no og_valid_o, and done_o 2 cycles after start_i.
REQ-046 The bench SHALL cover: start_i re-pulsed mid-packet with different header inputs -> ignored, and the og_* header outputs unchanged.
REQ-047 The bench SHALL cover: reset asserted at byte 30 of word 1 -> all outputs 0 the next cycle, no eof, and a following start sends a clean packet.

Source files
------------

// File: rtl/cnna_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cnna_pkg
// Brief    : Shared state encoding, packing and header constants for the result path.
// Revision : 1.0 - initial release
// ============================================================================
package cnna_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE    = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_READ    = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_CAPTURE = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_SEND    = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_DONE    = 3'd4;

    localparam int c_RESULT_W       = 512;
    localparam int c_UDP_BYTE_W     = 8;
    localparam int c_BYTES_PER_WORD = c_RESULT_W / c_UDP_BYTE_W;

    localparam int c_UDP_PORT_W = 16;
    localparam int c_IP_ADDR_W  = 32;

endpackage
`default_nettype wire

// File: rtl/udp_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : udp_result_tx
// Brief    : Reads result words from SRAM and streams them MSB-first as UDP bytes.
// Revision : 1.0 - initial release
// ============================================================================
module udp_result_tx
    import cnna_pkg::*;
#(
    parameter int MEM_ADDRESS_BIT_WIDTH = 8,
    parameter int MEM_DATA_BIT_WIDTH    = 512,
    parameter int UDP_DATA_BIT_WIDTH    = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_i,
    input  logic [MEM_ADDRESS_BIT_WIDTH-1:0] base_addr_i,
    input  logic [MEM_ADDRESS_BIT_WIDTH:0]   word_count_i,
    input  logic [c_UDP_PORT_W-1:0]          src_port_i,
    input  logic [c_UDP_PORT_W-1:0]          dest_port_i,
    input  logic [c_IP_ADDR_W-1:0]           dest_addr_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             mem_rd_en_o,
    output logic [MEM_ADDRESS_BIT_WIDTH-1:0] mem_addr_o,
    input  logic [MEM_DATA_BIT_WIDTH-1:0]    mem_data_i,
    output logic [UDP_DATA_BIT_WIDTH-1:0]    og_data_o,
    output logic                             og_valid_o,
    output logic                             og_sof_o,
    output logic                             og_eof_o,
    input  logic                             og_ready_i,
    output logic [c_UDP_PORT_W-1:0]          og_src_port_o,
    output logic [c_UDP_PORT_W-1:0]          og_dest_port_o,
    output logic [c_IP_ADDR_W-1:0]           og_dest_addr_o
);

    localparam int c_BPW   = MEM_DATA_BIT_WIDTH / UDP_DATA_BIT_WIDTH;
    localparam int c_IDX_W = $clog2(c_BPW);
    localparam int c_CNT_W = MEM_ADDRESS_BIT_WIDTH + 1;

    logic [c_STATE_W-1:0]          r_state;
    logic [MEM_DATA_BIT_WIDTH-1:0] r_shreg;
    logic [c_IDX_W-1:0]            r_byte_idx;
    logic [c_CNT_W-1:0]            r_words_left;
    logic                          r_first_word;

    logic               w_accept;
    logic               w_last_word;
    logic               w_last_byte;
    logic [c_IDX_W-1:0] w_next_idx;

    assign w_accept    = og_valid_o && og_ready_i;
    assign w_last_word = (r_words_left == c_CNT_W'(1));
    assign w_last_byte = (r_byte_idx == c_IDX_W'(c_BPW - 1));
    assign w_next_idx  = r_byte_idx + c_IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_shreg        <= '0;
            r_byte_idx     <= '0;
            r_words_left   <= '0;
            r_first_word   <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            mem_rd_en_o    <= 1'b0;
            mem_addr_o     <= '0;
            og_data_o      <= '0;
            og_valid_o     <= 1'b0;
            og_sof_o       <= 1'b0;
            og_eof_o       <= 1'b0;
            og_src_port_o  <= '0;
            og_dest_port_o <= '0;
            og_dest_addr_o <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        busy_o         <= 1'b1;
                        mem_addr_o     <= base_addr_i;
                        r_words_left   <= word_count_i;
                        r_first_word   <= 1'b1;
                        og_src_port_o  <= src_port_i;
                        og_dest_port_o <= dest_port_i;
                        og_dest_addr_o <= dest_addr_i;
                        if (word_count_i == '0) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            mem_rd_en_o <= 1'b1;
                            r_state     <= c_ST_READ;
                        end
                    end
                end

                c_ST_READ: begin
                    mem_rd_en_o <= 1'b0;
                    r_state     <= c_ST_CAPTURE;
                end

                // Byte 0 goes straight to the output; the shift register keeps the rest.
                c_ST_CAPTURE: begin
                    og_data_o  <= mem_data_i[MEM_DATA_BIT_WIDTH-1 -: UDP_DATA_BIT_WIDTH];
                    r_shreg    <= mem_data_i << UDP_DATA_BIT_WIDTH;
                    r_byte_idx <= '0;
                    og_valid_o <= 1'b1;
                    og_sof_o   <= r_first_word;
                    og_eof_o   <= 1'b0;
                    r_state    <= c_ST_SEND;
                end

                c_ST_SEND: begin
                    if (w_accept) begin
                        if (w_last_byte) begin
                            og_valid_o   <= 1'b0;
                            og_sof_o     <= 1'b0;
                            og_eof_o     <= 1'b0;
                            r_first_word <= 1'b0;
                            r_words_left <= r_words_left - c_CNT_W'(1);
                            if (w_last_word) begin
                                r_state <= c_ST_DONE;
                            end else begin
                                mem_addr_o  <= mem_addr_o + MEM_ADDRESS_BIT_WIDTH'(1);
                                mem_rd_en_o <= 1'b1;
                                r_state     <= c_ST_READ;
                            end
                        end else begin
                            og_data_o  <= r_shreg[MEM_DATA_BIT_WIDTH-1 -: UDP_DATA_BIT_WIDTH];
                            r_shreg    <= r_shreg << UDP_DATA_BIT_WIDTH;
                            r_byte_idx <= w_next_idx;
                            og_sof_o   <= 1'b0;
                            og_eof_o   <= w_last_word && (w_next_idx == c_IDX_W'(c_BPW - 1));
                        end
                    end
                end

                c_ST_DONE: begin
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udp_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_result_tx
// Brief    : Scoreboard bench for udp_result_tx with an SRAM model and monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_result_tx;
    import cnna_pkg::*;

    localparam int c_AW  = 8;
    localparam int c_DW  = 512;
    localparam int c_UW  = 8;
    localparam int c_BPW = 64;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_i;
    logic [c_AW-1:0]   base_addr_i;
    logic [c_AW:0]     word_count_i;
    logic [15:0]       src_port_i;
    logic [15:0]       dest_port_i;
    logic [31:0]       dest_addr_i;
    logic              busy_o;
    logic              done_o;
    logic              mem_rd_en_o;
    logic [c_AW-1:0]   mem_addr_o;
    logic [c_DW-1:0]   mem_data_i = '0;
    logic [c_UW-1:0]   og_data_o;
    logic              og_valid_o;
    logic              og_sof_o;
    logic              og_eof_o;
    logic              og_ready_i;
    logic [15:0]       og_src_port_o;
    logic [15:0]       og_dest_port_o;
    logic [31:0]       og_dest_addr_o;

    udp_result_tx #(
        .MEM_ADDRESS_BIT_WIDTH (c_AW),
        .MEM_DATA_BIT_WIDTH    (c_DW),
        .UDP_DATA_BIT_WIDTH    (c_UW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .word_count_i   (word_count_i),
        .src_port_i     (src_port_i),
        .dest_port_i    (dest_port_i),
        .dest_addr_i    (dest_addr_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .mem_rd_en_o    (mem_rd_en_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_i     (mem_data_i),
        .og_data_o      (og_data_o),
        .og_valid_o     (og_valid_o),
        .og_sof_o       (og_sof_o),
        .og_eof_o       (og_eof_o),
        .og_ready_i     (og_ready_i),
        .og_src_port_o  (og_src_port_o),
        .og_dest_port_o (og_dest_port_o),
        .og_dest_addr_o (og_dest_addr_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    exp_t       exp_q[$];
    logic [7:0] exp_rd[$];
    logic [63:0] exp_hdr;
    bit         stall_mode = 1'b0;

    int  rd_seen, byte_seen, valid_seen, sof_seen, eof_seen, done_cnt;
    int  t_start, t_first_rd, t_first_valid, last_valid_cyc;
    bit  have_last;
    logic       prev_valid, prev_ready, prev_reset, prev_sof, prev_eof;
    logic [7:0] prev_data;
    exp_t       mon_e;
    logic [7:0] mon_a;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Byte k of word a, k = 0 being the most significant byte.
    function automatic logic [7:0] fbyte(input logic [7:0] a, input int k);
        return 8'((int'(a) * 37 + k * 5 + 60) & 255);
    endfunction

    function automatic logic [c_DW-1:0] build_word(input logic [7:0] a);
        logic [c_DW-1:0] w;
        w = '0;
        for (int k = 0; k < c_BPW; k++) w[c_DW-1-8*k -: 8] = fbyte(a, k);
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: data valid exactly one cycle after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (mem_rd_en_o) mem_data_i <= build_word(mem_addr_o);
        else             mem_data_i <= {16{$urandom}};
    end

    initial begin
        og_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            og_ready_i = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: samples mid-cycle and pops the scoreboard on every read and accepted byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rd_en_o) begin
                if (rd_seen == 0) t_first_rd = cyc;
                rd_seen++;
                if (exp_rd.size() == 0) begin
                    check(1'b0, "unexpected_read", 64'(mem_addr_o), 64'hFFFF);
                end else begin
                    mon_a = exp_rd.pop_front();
                    check(mem_addr_o == mon_a, "read_addr", 64'(mem_addr_o), 64'(mon_a));
                end
            end
            if (og_valid_o) begin
                valid_seen++;
                if (valid_seen == 1) t_first_valid = cyc;
                if (!prev_valid && have_last && !og_sof_o)
                    check(cyc - last_valid_cyc - 1 == 2, "word_gap", 64'(cyc - last_valid_cyc - 1), 64'd2);
                last_valid_cyc = cyc;
                have_last      = 1'b1;
            end
            if (prev_valid && !prev_ready && !prev_reset)
                check(og_valid_o && og_data_o == prev_data && og_sof_o == prev_sof && og_eof_o == prev_eof,
                      "stall_stable", {53'd0, og_valid_o, og_data_o, og_sof_o, og_eof_o},
                      {53'd0, 1'b1, prev_data, prev_sof, prev_eof});
            if (og_valid_o && og_ready_i) begin
                byte_seen++;
                if (og_sof_o) sof_seen++;
                if (og_eof_o) eof_seen++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_byte", 64'(og_data_o), 64'hFFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check(og_data_o == mon_e.d && og_sof_o == mon_e.sof && og_eof_o == mon_e.eof,
                          "byte", {54'd0, og_data_o, og_sof_o, og_eof_o}, {54'd0, mon_e.d, mon_e.sof, mon_e.eof});
                    check({og_src_port_o, og_dest_port_o, og_dest_addr_o} == exp_hdr, "hdr_hold",
                          {og_src_port_o, og_dest_port_o, og_dest_addr_o}, exp_hdr);
                end
            end
            if (done_o) done_cnt++;
        end
        prev_valid = og_valid_o;
        prev_ready = og_ready_i;
        prev_reset = reset;
        prev_data  = og_data_o;
        prev_sof   = og_sof_o;
        prev_eof   = og_eof_o;
    end

    task automatic clear_stats();
        rd_seen = 0; byte_seen = 0; valid_seen = 0; sof_seen = 0; eof_seen = 0;
        t_first_rd = -1; t_first_valid = -1; have_last = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] base, input int cnt, input int nbytes);
        int   n;
        exp_t e;
        logic [7:0] a;
        n = 0;
        for (int w = 0; w < cnt; w++) begin
            a = base + 8'(w);
            exp_rd.push_back(a);
            for (int k = 0; k < c_BPW; k++) begin
                e.d   = fbyte(a, k);
                e.sof = (w == 0 && k == 0);
                e.eof = (w == cnt - 1 && k == c_BPW - 1);
                if (n < nbytes) exp_q.push_back(e);
                n++;
            end
        end
    endtask

    task automatic issue_start(input logic [7:0] base, input int cnt);
        @(posedge clk); #1;
        start_i      = 1'b1;
        base_addr_i  = base;
        word_count_i = 9'(cnt);
        src_port_i   = {8'hA0, base};
        dest_port_i  = {8'h5B, base};
        dest_addr_i  = {24'hC0A801, base};
        exp_hdr      = {src_port_i, dest_port_i, dest_addr_i};
        t_start      = cyc;
        @(posedge clk); #1;
        start_i      = 1'b0;
        base_addr_i  = 8'h77;
        word_count_i = 9'd5;
        src_port_i   = 16'hDEAD;
        dest_port_i  = 16'hBEEF;
        dest_addr_i  = 32'h0BAD_F00D;
    endtask

    task automatic junk_start();
        start_i = 1'b1; base_addr_i = 8'h99; word_count_i = 9'd1;
        src_port_i = 16'h1111; dest_port_i = 16'h2222; dest_addr_i = 32'h3333_4444;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic run_packet(input logic [7:0] base, input int cnt, input bit chk_lat,
                              input bit repulse, input string tag);
        int lat;
        bit got;
        push_exp(base, cnt, cnt * c_BPW);
        clear_stats();
        issue_start(base, cnt);
        got = 1'b0;
        lat = 0;
        fork
            begin
                for (int i = 0; i < cnt * c_BPW * 4 + 20 && !got; i++) begin
                    @(negedge clk);
                    if (done_o) begin got = 1'b1; lat = cyc - t_start; end
                end
            end
            begin
                if (repulse) begin
                    repeat (40) @(posedge clk);
                    #1;
                    junk_start();
                    repeat (66 * cnt + 1 - 42) @(posedge clk);
                    #1;
                    junk_start();
                end
            end
        join
        check(got, {tag, "_done_seen"}, 64'(got), 64'd1);
        if (got && chk_lat) check(lat == 66 * cnt + 2, {tag, "_done_lat"}, 64'(lat), 64'(66 * cnt + 2));
        if (cnt > 0) begin
            if (chk_lat) begin
                check(t_first_rd - t_start == 1, {tag, "_rd_lat"}, 64'(t_first_rd - t_start), 64'd1);
                check(t_first_valid - t_start == 3, {tag, "_valid_lat"}, 64'(t_first_valid - t_start), 64'd3);
            end
            check(sof_seen == 1 && eof_seen == 1, {tag, "_sof_eof"}, 64'({sof_seen[15:0], eof_seen[15:0]}), 64'h0001_0001);
            check(byte_seen == cnt * c_BPW, {tag, "_bytes"}, 64'(byte_seen), 64'(cnt * c_BPW));
            check(rd_seen == cnt, {tag, "_reads"}, 64'(rd_seen), 64'(cnt));
        end else begin
            check(rd_seen == 0, {tag, "_no_read"}, 64'(rd_seen), 64'd0);
            check(valid_seen == 0, {tag, "_no_valid"}, 64'(valid_seen), 64'd0);
        end
        repeat (6) @(posedge clk);
        #1;
        check(exp_q.size() == 0 && exp_rd.size() == 0, {tag, "_sb_empty"},
              64'(exp_q.size() + exp_rd.size()), 64'd0);
        check(!busy_o, {tag, "_idle"}, 64'(busy_o), 64'd0);
        if (cnt > 0)
            check({og_src_port_o, og_dest_port_o, og_dest_addr_o} == exp_hdr, {tag, "_hdr_after"},
                  {og_src_port_o, og_dest_port_o, og_dest_addr_o}, exp_hdr);
    endtask

    task automatic check_all_zero(input string tag);
        check({busy_o, done_o, mem_rd_en_o, og_valid_o, og_sof_o, og_eof_o} == 6'd0, {tag, "_ctrl"},
              64'({busy_o, done_o, mem_rd_en_o, og_valid_o, og_sof_o, og_eof_o}), 64'd0);
        check(mem_addr_o == '0, {tag, "_addr"}, 64'(mem_addr_o), 64'd0);
        check(og_data_o == '0, {tag, "_data"}, 64'(og_data_o), 64'd0);
        check({og_src_port_o, og_dest_port_o, og_dest_addr_o} == 64'd0, {tag, "_hdr"},
              {og_src_port_o, og_dest_port_o, og_dest_addr_o}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  d0;
        bit  hit;
        reset = 1'b1; start_i = 1'b0; base_addr_i = '0; word_count_i = '0;
        src_port_i = '0; dest_port_i = '0; dest_addr_i = '0; exp_hdr = '0;
        done_cnt = 0;
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        run_packet(8'h10, 1, 1'b1, 1'b0, "one_word");
        run_packet(8'hFE, 3, 1'b1, 1'b0, "wrap3");
        stall_mode = 1'b1;
        run_packet(8'h10, 2, 1'b0, 1'b0, "stall");
        stall_mode = 1'b0;
        run_packet(8'h00, 0, 1'b1, 1'b0, "zero");
        run_packet(8'h30, 2, 1'b1, 1'b1, "repulse");

        // Abort a two-word packet while byte 30 of word 1 is on the bus.
        push_exp(8'h40, 2, c_BPW + 30);
        clear_stats();
        d0 = done_cnt;
        issue_start(8'h40, 2);
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (byte_seen == c_BPW + 30 && og_valid_o) begin hit = 1'b1; break; end
        end
        check(hit, "abort_reached", 64'(byte_seen), 64'(c_BPW + 30));
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("abort");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check(eof_seen == 0, "abort_no_eof", 64'(eof_seen), 64'd0);
        check(done_cnt == d0, "abort_no_done", 64'(done_cnt), 64'(d0));
        check(exp_q.size() == 0 && exp_rd.size() == 0, "abort_sb_empty",
              64'(exp_q.size() + exp_rd.size()), 64'd0);

        run_packet(8'h20, 1, 1'b1, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
